// File: rtl/log_class_argmin_if.sv
// Streaming class-code input and decision readout bundle for log_class_argmin.
// Width parameters must match the ones given to the attached log_class_argmin.
interface log_class_argmin_if #(
  parameter int M       = 8,
  parameter int N_CLASS = 4
);
  localparam int CW = $clog2(N_CLASS);

  logic          start;
  logic          data_valid;
  logic [M-1:0]  data_in;
  logic          busy;
  logic          decision_valid;
  logic [CW-1:0] decision;
  logic [M-1:0]  best_code;
  logic [M-1:0]  margin;

  modport master (
    output start, data_valid, data_in,
    input  busy, decision_valid, decision, best_code, margin
  );

  modport slave (
    input  start, data_valid, data_in,
    output busy, decision_valid, decision, best_code, margin
  );
endinterface

// File: rtl/log_class_argmin.sv
// Serial argmin over N_CLASS -log2 probability codes: smallest code wins, lowest index on ties.
// Define LOG_MARGIN_EN to build second-best tracking and drive margin = second - best.
module log_class_argmin #(
  parameter int  M       = 8,
  parameter int  N_CLASS = 4,
  localparam int CW      = $clog2(N_CLASS)
) (
  input  logic              clk,
  input  logic              rst,
  log_class_argmin_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_base, cnt_nxt;
  logic [CW-1:0] idx, idx_base, idx_nxt;
  logic [M-1:0]  best, best_base, best_nxt;
  logic [CW-1:0] decision_q;
  logic [M-1:0]  best_code_q;
  logic          take;
  logic          last;

  // A start restarts the pass, and a code presented with it is already class 0.
  assign take = bus.data_valid && (bus.start || (state == COLLECT));
  assign last = take && (cnt_base == CW'(N_CLASS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = COLLECT;
      COLLECT: if (last) state_nxt = DONE;
               else if (bus.start) state_nxt = COLLECT;
      DONE:    if (bus.start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = 1'b0;
    bus.decision_valid = 1'b0;
    case (state)
      COLLECT: bus.busy           = 1'b1;
      DONE:    bus.decision_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_base  = bus.start ? '0 : cnt;
    idx_base  = bus.start ? '0 : idx;
    best_base = bus.start ? '1 : best;
    cnt_nxt   = cnt_base;
    idx_nxt   = idx_base;
    best_nxt  = best_base;
    if (take) begin
      cnt_nxt = cnt_base + CW'(1);
      if (bus.data_in < best_base) begin
        best_nxt = bus.data_in;
        idx_nxt  = cnt_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      best <= '1;
    end else begin
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
      best <= best_nxt;
    end
  end

  // Result registers load on the edge that takes the final class.
  always_ff @(posedge clk) begin
    if (rst) begin
      decision_q  <= '0;
      best_code_q <= '0;
    end else if (last) begin
      decision_q  <= idx_nxt;
      best_code_q <= best_nxt;
    end else if (bus.start) begin
      decision_q  <= '0;
      best_code_q <= '0;
    end
  end

  assign bus.decision  = decision_q;
  assign bus.best_code = best_code_q;

`ifdef LOG_MARGIN_EN
  logic [M-1:0] second, second_base, second_nxt;
  logic [M-1:0] margin_q;

  always_comb begin
    second_base = bus.start ? '1 : second;
    second_nxt  = second_base;
    if (take) begin
      if (bus.data_in < best_base)        second_nxt = best_base;
      else if (bus.data_in < second_base) second_nxt = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) second <= '1;
    else     second <= second_nxt;
  end

  // second >= best always holds, so the difference never wraps.
  always_ff @(posedge clk) begin
    if (rst)            margin_q <= '0;
    else if (last)      margin_q <= second_nxt - best_nxt;
    else if (bus.start) margin_q <= '0;
  end

  assign bus.margin = margin_q;
`else
  assign bus.margin = '0;
`endif

endmodule

// File: tb/tb_log_class_argmin.sv
// Self-checking bench for log_class_argmin: vector table through a scoreboard queue,
// plus hand-written restart / reset / post-decision sequences.
module tb_log_class_argmin;

  localparam int M       = 8;
  localparam int N_CLASS = 4;
`ifdef LOG_MARGIN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  typedef struct {
    logic [7:0] c0, c1, c2, c3;
    int         dec;
    int         best;
    int         mrg;
  } vec_t;

  typedef struct {
    int dec;
    int best;
    int mrg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[6];

  log_class_argmin_if #(.M(M), .N_CLASS(N_CLASS)) bus ();

  log_class_argmin #(.M(M), .N_CLASS(N_CLASS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout act=running req=finished");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int a, int b, int c, int d, int dec, int best, int mrg);
    vec_t v;
    v.c0 = 8'(a); v.c1 = 8'(b); v.c2 = 8'(c); v.c3 = 8'(d);
    v.dec = dec; v.best = best; v.mrg = MEN ? mrg : 0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic push(int dec, int best, int mrg);
    exp_t e;
    e.dec = dec; e.best = best; e.mrg = MEN ? mrg : 0;
    sb.push_back(e);
  endtask

  task automatic drive(int code);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'(code);
    step();
    bus.data_valid = 1'b0;
  endtask

  // Bounded wait for decision_valid, then compare against the scoreboard head.
  task automatic collect_result(string name);
    int   n = 0;
    exp_t e;
    while (!bus.decision_valid && n < 8) begin
      step();
      n++;
    end
    chk({name, "_latency"}, n, 0);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({name, "_decision"},  int'(bus.decision),  e.dec);
    chk({name, "_best_code"}, int'(bus.best_code), e.best);
    chk({name, "_margin"},    int'(bus.margin),    e.mrg);
  endtask

  task automatic run_vec(vec_t v, bit gap, string name);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({name, "_busy"}, int'(bus.busy), 1);
    push(v.dec, v.best, v.mrg);
    drive(int'(v.c0));
    drive(int'(v.c1));
    if (gap) begin
      repeat (3) step();
      chk({name, "_gap_busy"}, int'(bus.busy), 1);
    end
    drive(int'(v.c2));
    chk({name, "_early_dv"}, int'(bus.decision_valid), 0);
    drive(int'(v.c3));
    collect_result(name);
  endtask

  initial begin
    vecs[0] = mk(40, 12, 90, 33, 1, 12, 21);
    vecs[1] = mk(20, 20, 5, 5, 2, 5, 0);
    vecs[2] = mk(255, 255, 255, 255, 0, 255, 0);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(200, 100, 150, 101, 1, 100, 1);
    vecs[5] = mk(9, 3, 3, 1, 3, 1, 2);

    bus.start      = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy",      int'(bus.busy),           0);
    chk("rst_dv",        int'(bus.decision_valid), 0);
    chk("rst_decision",  int'(bus.decision),       0);
    chk("rst_best_code", int'(bus.best_code),      0);
    chk("rst_margin",    int'(bus.margin),         0);

    // Codes ignored while idle.
    drive(3);
    chk("idle_ignore_busy", int'(bus.busy), 0);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], (i == 1), $sformatf("vec%0d", i));

    // Restart mid-collection; a code presented with start is class 0.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rs_dv_cleared", int'(bus.decision_valid), 0);
    drive(50);
    drive(10);
    bus.start = 1'b1;
    drive(7);
    bus.start = 1'b0;
    push(3, 6, 1);
    drive(8);
    drive(9);
    chk("rs_busy", int'(bus.busy), 1);
    drive(6);
    collect_result("restart");

    // Reset in the middle of a pass, then valids without start.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drive(30);
    repeat (3) step();
    drive(25);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(1);
    chk("mid_rst_busy",      int'(bus.busy),           0);
    chk("mid_rst_dv",        int'(bus.decision_valid), 0);
    chk("mid_rst_decision",  int'(bus.decision),       0);
    chk("mid_rst_best_code", int'(bus.best_code),      0);
    chk("mid_rst_margin",    int'(bus.margin),         0);

    // Extra codes after the decision must not disturb it; start then drops decision_valid.
    run_vec(vecs[0], 1'b0, "hold");
    drive(0);
    drive(0);
    chk("hold_dv",        int'(bus.decision_valid), 1);
    chk("hold_decision",  int'(bus.decision),       1);
    chk("hold_best_code", int'(bus.best_code),      12);
    chk("hold_margin",    int'(bus.margin),         MEN ? 21 : 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("hold_start_dv",   int'(bus.decision_valid), 0);
    chk("hold_start_busy", int'(bus.busy),           1);

    // Finish that pass, then start together with data from DONE.
    push(3, 2, 2);
    drive(4);
    drive(6);
    drive(7);
    drive(2);
    collect_result("pass_b");
    bus.start = 1'b1;
    drive(3);
    bus.start = 1'b0;
    push(0, 3, 1);
    drive(5);
    drive(4);
    drive(9);
    collect_result("done_start_data");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_class_argmin.md
Name: log_class_argmin

Overview:
- Downstream of the per-column log-domain accumulation chain in the stochastic/log inference array.
- Receives one accumulated log-likelihood word per class from the last chain stage, serially, one class per valid cycle.
- Selects the most probable class. Values are -log2 probability codes, so the smallest code wins.
- Reports the winning class index and a confidence margin to the chip readout / scan-out logic.

Parameters:
- M, 8, width of each log-likelihood code (matches the chain DATA width).
- N_CLASS, 4, number of classes presented per inference (>= 2).
- CW, $clog2(N_CLASS), width of class index; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: begin a new decision, clears previous result.
- data_valid  in  1  data_in holds the code for the next class (class order 0..N_CLASS-1).
- data_in  in  M  accumulated -log2 probability code from the chain output (DATA_next of last stage).
- busy  out  1  high while collecting class codes.
- decision_valid  out  1  high from result ready until next start or rst.
- decision  out  CW  index of winning class.
- best_code  out  M  code of winning class.
- margin  out  M  second-best code minus best code (confidence); see Optional Feature.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. busy=0, decision_valid=0, decision=0, best_code=0, margin=0. Class counter=0, internal best/second=all-ones.
- States:
  - IDLE: data_valid ignored. start -> COLLECT; counter=0, best=second='1, decision_valid=0.
  - COLLECT: busy=1. Each data_valid cycle is one class, index=counter.
    - data_in < best: second<=best, best<=data_in, idx<=counter.
    - Else if data_in < second: second<=data_in.
    - counter increments.
    - On the valid with counter==N_CLASS-1: go to DONE on the next edge. No wrap into a second pass.
  - DONE: busy=0, decision_valid=1; outputs hold stable. data_valid ignored. start -> COLLECT (clears decision_valid the same edge).
- Latency: decision_valid rises on the clock edge that samples the last (N_CLASS-th) valid. Visible the cycle after that valid is presented.
- Comparisons are unsigned, M bits; no arithmetic overflow (margin = second - best >= 0 by construction).
- Ties: strict < means the lowest class index among equal codes wins; an equal code updates second (margin 0).
- Saturated codes ('1) are legal. If all classes are '1: decision=0, best_code='1, margin=0.
- start during COLLECT: restart. The partial result is discarded, counter=0. A data_valid on the same cycle as start counts as class 0.
- start and data_valid in IDLE/DONE on the same cycle: start taken, data counted as class 0.
- rst mid-COLLECT: immediate return to IDLE with reset values; no decision_valid.
- Gaps (data_valid=0) in COLLECT are allowed, indefinitely; state holds.

Optional Feature:
- Macro LOG_MARGIN_EN.
- Defined: second-best tracking is built and margin = second - best, registered with decision.
- Undefined: second-best register and subtractor are not built. margin is tied to 0. All other behaviour is identical.

Test Plan:
- Reset, start, codes 40,12,90,33 -> decision_valid after 4th valid; decision=1, best_code=12, margin=21 (0 without LOG_MARGIN_EN).
- Codes 20,20,5,5 -> decision=2, best_code=5, margin=0 (lowest index wins tie).
- Codes 255,255,255,255 -> decision=0, best_code=255, margin=0.
- Codes 50,10 then start, then 7,8,9,6 -> decision=3, best_code=6, margin=1; the first pass leaves no trace.
- Codes 30, gap 3 cycles, 25, rst asserted, then 5 valid cycles with no start -> busy=0, decision_valid=0, all outputs 0.
- After DONE (decision=1), 2 extra data_valid with code 0 -> outputs unchanged; next start drops decision_valid the following cycle.
